// File: rtl/mips_run_controller.sv
// mips_run_controller
// Run sequencer between the board clock/reset and the MIPS core. After a
// start request it holds the core in reset for RESET_CYCLES cycles. It then
// enables the core and counts the cycles it runs. It stops the core when the
// cycle budget is used up or when an external halt is requested.
//
// Ports
//   clock        system clock, rising edge
//   reset        asynchronous, active-high controller reset
//   start        level; begins a run when sampled in IDLE or DONE
//   halt_req     level; stops the core when sampled in RUN
//   core_reset   reset to the core, active-high
//   core_run     clock enable to the core
//   cycle_count  cycles core_run has been high in the current run
//   done         high while in DONE
//   state        IDLE=0, HOLD=1, RUN=2, DONE=3 (debug)
module mips_run_controller #(
  parameter int RESET_CYCLES = 2,
  parameter int MAX_CYCLES   = 16,
  parameter int CNT_W        = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             halt_req,
  output logic             core_reset,
  output logic             core_run,
  output logic [CNT_W-1:0] cycle_count,
  output logic             done,
  output logic [1:0]       state
);

  if (RESET_CYCLES < 1 || RESET_CYCLES > 255) begin : g_bad_reset_cycles
    $error("mips_run_controller: RESET_CYCLES must be in 1..255");
  end
  if (CNT_W < 1 || MAX_CYCLES < 0 ||
      (CNT_W < 63 && longint'(MAX_CYCLES) > ((longint'(1) << CNT_W) - 1))) begin : g_bad_max_cycles
    $error("mips_run_controller: MAX_CYCLES does not fit in CNT_W bits");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [7:0]     HOLD_LOAD = 8'(RESET_CYCLES - 1);
  localparam logic [CNT_W:0] MAX_W     = (CNT_W+1)'(MAX_CYCLES);

  // Increment that sticks at all-ones instead of wrapping (unlimited budget).
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // True when this RUN cycle is the last one the budget allows.
  function automatic logic budget_hit(input logic [CNT_W-1:0] v);
    return (MAX_CYCLES != 0) && (({1'b0, v} + (CNT_W+1)'(1)) == MAX_W);
  endfunction

  state_t           st, st_nxt;
  logic [7:0]       hold, hold_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st         <= S_IDLE;
      hold       <= 8'd0;
      cnt        <= '0;
      core_reset <= 1'b1;
      core_run   <= 1'b0;
      done       <= 1'b0;
    end else begin
      st         <= st_nxt;
      hold       <= hold_nxt;
      cnt        <= cnt_nxt;
      // Output flops are loaded from the next-state decode so that they
      // always match the state register without a combinational tail.
      core_reset <= (st_nxt == S_IDLE) || (st_nxt == S_HOLD);
      core_run   <= (st_nxt == S_RUN);
      done       <= (st_nxt == S_DONE);
    end
  end

  always_comb begin
    st_nxt   = st;
    hold_nxt = hold;
    cnt_nxt  = cnt;
    case (st)
      S_IDLE, S_DONE: begin
        if (start) begin
          st_nxt   = S_HOLD;
          hold_nxt = HOLD_LOAD;
          cnt_nxt  = '0;
        end
      end
      S_HOLD: begin
        if (hold == 8'd0) st_nxt = S_RUN;
        else              hold_nxt = hold - 8'd1;
      end
      S_RUN: begin
        // The exit cycle still counts as a run cycle.
        cnt_nxt = sat_inc(cnt);
        if (halt_req || budget_hit(cnt)) st_nxt = S_DONE;
      end
      default: st_nxt = S_IDLE;
    endcase
  end

  assign cycle_count = cnt;
  assign state       = st;

endmodule
